// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a five-stage pipeline. It combines the memory handshakes, EX-stage
// redirects and load-use hazards into per-stage enable/flush strobes, and keeps perf counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic             br_taken,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rd,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  output logic             imem_read,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             memwb_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             err_timeout
);

  // state   | meaning
  // S_INIT  | first cycle after reset: bubble every stage, PC held, no fetch
  // S_RUN   | last cycle advanced (or first operating cycle)
  // S_STALL | waiting on a memory response; pipeline fully held
  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } state_t;

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMER_MAX = (TIMEOUT > 0) ? TW'(TIMEOUT) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic             done_i_q, done_i_d;
  logic             done_d_q, done_d_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic running;
  logic ok_i;
  logic ok_d;
  logic advance;
  logic load_use;

  assign running  = (state_q == S_RUN) || (state_q == S_STALL);
  assign ok_i     = done_i_q | imem_resp;
  assign ok_d     = !dmem_req | done_d_q | dmem_resp;
  assign advance  = ok_i & ok_d;
  assign load_use = idex_mem_read && (idex_rd != 5'd0) &&
                    ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      done_i_q    <= 1'b0;
      done_d_q    <= 1'b0;
      timer_q     <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      done_i_q    <= done_i_d;
      done_d_q    <= done_d_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next-state, handshake memory and bookkeeping.
  always_comb begin
    state_d     = state_q;
    done_i_d    = done_i_q;
    done_d_d    = done_d_q;
    timer_d     = timer_q;
    err_d       = err_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    unique case (state_q)
      S_INIT: begin
        state_d  = S_RUN;
        done_i_d = 1'b0;
        done_d_d = 1'b0;
      end
      S_RUN, S_STALL: begin
        if (advance) begin
          state_d  = S_RUN;
          done_i_d = 1'b0;
          done_d_d = 1'b0;
          timer_d  = '0;
          if (br_taken && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
          end
        end else begin
          state_d  = S_STALL;
          done_i_d = done_i_q | imem_resp;
          done_d_d = done_d_q | (dmem_resp & dmem_req);
          if (stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
          end
          if (TIMEOUT != 0) begin
            // Saturate at the threshold so a very long stall cannot wrap the timer.
            if (timer_q != TIMER_MAX) begin
              timer_d = timer_q + TW'(1);
            end
            if (timer_d == TIMER_MAX) begin
              err_d = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // Stage strobes; forced low while reset is held so the datapath sees a quiet interface.
  always_comb begin
    imem_read   = 1'b0;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    memwb_en    = 1'b0;
    memwb_flush = 1'b0;

    if (rst_n) begin
      if (state_q == S_INIT) begin
        ifid_en     = 1'b1;
        ifid_flush  = 1'b1;
        idex_en     = 1'b1;
        idex_flush  = 1'b1;
        exmem_en    = 1'b1;
        exmem_flush = 1'b1;
        memwb_en    = 1'b1;
        memwb_flush = 1'b1;
      end else if (running) begin
        imem_read = 1'b1;
        if (advance) begin
          exmem_en = 1'b1;
          memwb_en = 1'b1;
          idex_en  = 1'b1;
          if (br_taken) begin
            // A redirect squashes both younger stages, which also covers any load-use pair.
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use) begin
            idex_flush = 1'b1;
          end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
          end
        end
      end
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign err_timeout = err_q;

endmodule
